// File: rtl/debug_dump_sender_pkg.sv
// Shared definitions for the debug dump sender: frame constants, command bytes
// shared with the serial command receiver, and the dump FSM state encoding.
// Optional feature macro: DUMP_CHECKSUM_EN (adds the CHECK state).
package debug_dump_sender_pkg;

    localparam logic [7:0] DUMP_HEADER = 8'hA5;
    localparam logic [7:0] CMD_RECORD  = 8'h30;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HEADER = 4'd1,
        ST_CNT_HI = 4'd2,
        ST_CNT_LO = 4'd3,
        ST_FETCH  = 4'd4,
        ST_LOAD   = 4'd5,
        ST_SHIFT  = 4'd6,
`ifdef DUMP_CHECKSUM_EN
        ST_CHECK  = 4'd7,
`endif
        ST_DONE   = 4'd8
    } dump_state_t;

endpackage

// File: rtl/debug_byte_serializer.sv
// Byte serializer for the debug dump sender: captures one sample word and
// presents it one byte at a time, most significant byte first.
// Optional feature macro of the enclosing design: DUMP_CHECKSUM_EN (not used here).
module debug_byte_serializer #(
    parameter int SAMPLE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [SAMPLE_WIDTH-1:0] word,
    input  logic                    advance,
    output logic [7:0]              byte_out,
    output logic                    last_byte
);

    localparam int NBYTES = SAMPLE_WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [CW-1:0]           byte_cnt;

    // Sample word holder: shifts left one byte per accepted byte so the next byte sits on top.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_reg <= word;
        end else if (advance) begin
            shift_reg <= shift_reg << 8;
        end
    end

    // Counts bytes already emitted from the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (load) begin
            byte_cnt <= '0;
        end else if (advance) begin
            byte_cnt <= byte_cnt + CW'(1);
        end
    end

    assign byte_out  = shift_reg[SAMPLE_WIDTH-1 -: 8];
    assign last_byte = (byte_cnt == CW'(NBYTES - 1));

endmodule

// File: rtl/debug_dump_sender.sv
// Debug dump sender: after recording, reads samples from the record RAM and
// streams a framed byte sequence (A5, count hi, count lo, samples MSB first,
// optional XOR checksum) into the TX FIFO with valid/ready handshaking.
// Optional feature macro: DUMP_CHECKSUM_EN (appends the checksum byte).
module debug_dump_sender
    import debug_dump_sender_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 32,
    parameter int DEPTH_BITS   = 8
) (
    input  logic                    comm_clock,
    input  logic                    comm_reset,
    input  logic                    dump_start,
    input  logic [DEPTH_BITS:0]     sample_count,
    output logic [DEPTH_BITS-1:0]   mem_addr,
    input  logic [SAMPLE_WIDTH-1:0] mem_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    output logic                    dump_busy,
    output logic                    dump_done
);

    localparam logic [15:0] MAX_COUNT = 16'(1 << DEPTH_BITS);

`ifdef DUMP_CHECKSUM_EN
    localparam dump_state_t AFTER_DATA = ST_CHECK;
`else
    localparam dump_state_t AFTER_DATA = ST_DONE;
`endif

    dump_state_t           state;
    dump_state_t           state_n;
    logic [15:0]           count_q;
    logic [15:0]           req_count;
    logic [15:0]           clamped_count;
    logic [DEPTH_BITS-1:0] addr_q;
    logic                  last_sample;
    logic                  load_word;
    logic                  advance_byte;
    logic [7:0]            ser_byte;
    logic                  ser_last;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign req_count     = 16'(sample_count);
    assign clamped_count = (req_count > MAX_COUNT) ? MAX_COUNT : req_count;
    assign last_sample   = (16'(addr_q) == (count_q - 16'd1));
    assign mem_addr      = addr_q;
    assign dump_busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign dump_done     = (state == ST_DONE);

    debug_byte_serializer #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) u_serializer (
        .clk      (comm_clock),
        .rst      (comm_reset),
        .load     (load_word),
        .word     (mem_data),
        .advance  (advance_byte),
        .byte_out (ser_byte),
        .last_byte(ser_last)
    );

    // FSM state register.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode; each byte state holds until its byte is accepted.
    always_comb begin
        state_n      = state;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        load_word    = 1'b0;
        advance_byte = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dump_start) state_n = ST_HEADER;
            end
            ST_HEADER: begin
                out_valid = 1'b1;
                out_data  = DUMP_HEADER;
                if (out_ready) state_n = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                out_valid = 1'b1;
                out_data  = count_q[15:8];
                if (out_ready) state_n = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                out_valid = 1'b1;
                out_data  = count_q[7:0];
                if (out_ready) state_n = (count_q == 16'd0) ? AFTER_DATA : ST_FETCH;
            end
            ST_FETCH: begin
                state_n = ST_LOAD;
            end
            ST_LOAD: begin
                load_word = 1'b1;
                state_n   = ST_SHIFT;
            end
            ST_SHIFT: begin
                out_valid = 1'b1;
                out_data  = ser_byte;
                if (out_ready) begin
                    advance_byte = 1'b1;
                    if (ser_last) state_n = last_sample ? AFTER_DATA : ST_FETCH;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHECK: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                if (out_ready) state_n = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Latch the clamped count on an accepted start; step the RAM address after each full sample.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            count_q <= 16'd0;
            addr_q  <= '0;
        end else begin
            if (state == ST_IDLE && dump_start) begin
                count_q <= clamped_count;
                addr_q  <= '0;
            end else if (state == ST_SHIFT && out_ready && ser_last && !last_sample) begin
                addr_q <= addr_q + DEPTH_BITS'(1);
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every byte sent after the header.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            csum_q <= 8'h00;
        end else if (state == ST_IDLE && dump_start) begin
            csum_q <= 8'h00;
        end else if (out_valid && out_ready &&
                     (state == ST_CNT_HI || state == ST_CNT_LO || state == ST_SHIFT)) begin
            csum_q <= csum_q ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_debug_dump_sender.sv
// Testbench for debug_dump_sender: a reference model builds each expected frame
// into a queue; an independent monitor pops and compares every accepted byte.
// Optional feature macro: DUMP_CHECKSUM_EN (expects the trailing checksum byte).
module tb_debug_dump_sender;

    logic        comm_clock;
    logic        comm_reset;
    logic        dump_start;
    logic [8:0]  sample_count;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        dump_busy;
    logic        dump_done;

`ifdef DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    debug_dump_sender #(
        .SAMPLE_WIDTH(32),
        .DEPTH_BITS  (8)
    ) dut (
        .comm_clock  (comm_clock),
        .comm_reset  (comm_reset),
        .dump_start  (dump_start),
        .sample_count(sample_count),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .dump_busy   (dump_busy),
        .dump_done   (dump_done)
    );

    initial comm_clock = 1'b0;
    always #5 comm_clock = ~comm_clock;

    logic [31:0] ram [256];
    always @(posedge comm_clock) mem_data <= ram[mem_addr];

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         max_addr = 0;
    int         ready_mode = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: frame built straight from the frame rules.
    task automatic push_frame(input int sc);
        int cnt;
        logic [7:0] ck;
        logic [7:0] b;
        logic [31:0] w;
        cnt = (sc > 256) ? 256 : sc;
        ck = 8'h00;
        exp_q.push_back(8'hA5);
        b = 8'((cnt >> 8) & 255); exp_q.push_back(b); ck ^= b;
        b = 8'(cnt & 255);        exp_q.push_back(b); ck ^= b;
        for (int a = 0; a < cnt; a++) begin
            w = ram[a];
            for (int k = 3; k >= 0; k--) begin
                b = 8'((w >> (8 * k)) & 32'hFF);
                exp_q.push_back(b);
                ck ^= b;
            end
        end
        if (CSUM) exp_q.push_back(ck);
    endtask

    task automatic pulse_start(input int sc);
        dump_start   = 1'b1;
        sample_count = 9'(sc);
        @(posedge comm_clock); #1;
        dump_start   = 1'b0;
    endtask

    task automatic run_dump(input int sc, input int mode, input bit extra);
        int cnt;
        int d0;
        int waited;
        cnt = (sc > 256) ? 256 : sc;
        push_frame(sc);
        ready_mode = mode;
        max_addr = 0;
        xfer_cnt = 0;
        d0 = done_cnt;
        pulse_start(sc);
        check("busy_after_start", {31'd0, dump_busy}, 32'd1);
        if (extra) begin
            repeat (40) @(posedge comm_clock);
            #1;
            check("busy_mid_dump", {31'd0, dump_busy}, 32'd1);
            pulse_start(1);
        end
        waited = 0;
        while (done_cnt == d0 && waited < 40000) begin
            @(posedge comm_clock); #1;
            waited++;
        end
        check("done_arrived", done_cnt - d0, 1);
        check("max_addr", max_addr, (cnt == 0) ? 0 : cnt - 1);
        repeat (3) @(posedge comm_clock);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("idle_not_busy", {31'd0, dump_busy}, 32'd0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Ready pattern driver.
    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge comm_clock); #1;
            cyc++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 6 == 5);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected bytes on each handshake, watches stall stability and done pulses.
    initial begin
        logic       stalled;
        logic [7:0] stall_data;
        logic       prev_done;
        stalled = 1'b0;
        stall_data = 8'h00;
        prev_done = 1'b0;
        forever begin
            @(negedge comm_clock);
            if (comm_reset) begin
                stalled = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (dump_busy && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
                if (stalled) begin
                    check("stall_valid_held", {31'd0, out_valid}, 32'd1);
                    if (out_valid) check("stall_data_stable", {24'd0, out_data}, {24'd0, stall_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h expected no byte at %0t", out_data, $time);
                    end else begin
                        check("byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                    end
                    xfer_cnt++;
                end
                stalled = out_valid && !out_ready;
                stall_data = out_data;
                if (dump_done) begin
                    check("done_all_bytes_sent", exp_q.size(), 0);
                    check("done_valid_low", {31'd0, out_valid}, 32'd0);
                    check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                    done_cnt++;
                end
                prev_done = dump_done;
            end
        end
    end

    initial begin
        int w;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        comm_reset = 1'b1;
        dump_start = 1'b0;
        sample_count = 9'd0;
        repeat (3) @(posedge comm_clock);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_busy", {31'd0, dump_busy}, 32'd0);
        check("rst_done", {31'd0, dump_done}, 32'd0);
        comm_reset = 1'b0;
        repeat (2) @(posedge comm_clock);
        #1;

        // Basic two-sample frame.
        ram[0] = 32'h12345678;
        ram[1] = 32'hDEADBEEF;
        run_dump(2, 0, 1'b0);

        // Empty dump.
        run_dump(0, 0, 1'b0);
        check("empty_addr_zero", {24'd0, mem_addr}, 32'd0);

        // Backpressure: fixed long stalls, then random toggling.
        for (int i = 2; i < 256; i++) ram[i] = $urandom;
        run_dump(3, 1, 1'b0);
        run_dump(5, 2, 1'b0);

        // Clamp to full buffer with a stray start mid-dump.
        run_dump(300, 2, 1'b1);

        // Reset during the third sample byte.
        ready_mode = 0;
        push_frame(4);
        xfer_cnt = 0;
        pulse_start(4);
        w = 0;
        while (xfer_cnt < 5 && w < 200) begin
            @(posedge comm_clock); #1;
            w++;
        end
        check("reached_sample_byte", {31'd0, xfer_cnt >= 5}, 32'd1);
        comm_reset = 1'b1;
        #1;
        check("abort_valid_low", {31'd0, out_valid}, 32'd0);
        check("abort_busy_low", {31'd0, dump_busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge comm_clock);
        #1;
        comm_reset = 1'b0;
        @(posedge comm_clock); #1;
        run_dump(2, 0, 1'b0);

        // Random dumps.
        for (int t = 0; t < 6; t++) begin
            run_dump(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
